// File: rtl/instruction_loader.sv
// Streams a length-prefixed program from a byte interface into instruction memory,
// holding the CPU in reset until the whole program has been written.
module instruction_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iStart,
  input  logic [7:0]  iByte,
  input  logic        iByteValid,
  output logic        oByteReady,
  output logic        oWriteEnable,
  output logic [15:0] oWriteAddress,
  output logic [27:0] oInstruction,
  output logic        oCpuReset,
  output logic        oDone,
  output logic        oError
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CNT_HI = 4'd1,
    S_CNT_LO = 4'd2,
    S_BYTE0  = 4'd3,
    S_BYTE1  = 4'd4,
    S_BYTE2  = 4'd5,
    S_BYTE3  = 4'd6,
    S_WRITE  = 4'd7,
    S_DONE   = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] addr_q, addr_d;
  logic [27:0] instr_q, instr_d;
  logic        accept_s;
  logic [15:0] n_s;

  function automatic logic ready_in(input state_t s);
    case (s)
      S_CNT_HI, S_CNT_LO, S_BYTE0, S_BYTE1, S_BYTE2, S_BYTE3: ready_in = 1'b1;
      default:                                                ready_in = 1'b0;
    endcase
  endfunction

  assign accept_s      = iByteValid & oByteReady;
  assign n_s           = {count_q[15:8], iByte};
  assign oWriteAddress = addr_q;
  assign oInstruction  = instr_q;

  // Next-state and datapath update; bytes only move state when accepted.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (iStart) begin
          state_d = S_CNT_HI;
          addr_d  = 16'h0000;
        end else begin
          state_d = state_q;
        end
      end
      S_CNT_HI: begin
        if (accept_s) begin
          count_d = {iByte, 8'h00};
          state_d = S_CNT_LO;
        end else begin
          state_d = S_CNT_HI;
        end
      end
      S_CNT_LO: begin
        if (accept_s) begin
          count_d = n_s;
          if (n_s == 16'h0000) begin
            state_d = S_DONE;
          end else if ({1'b0, n_s} > MaxWords) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_BYTE0;
          end
        end else begin
          state_d = S_CNT_LO;
        end
      end
      S_BYTE0: begin
        if (accept_s) begin
          if (iByte[7:4] != 4'h0) begin
            state_d = S_ERROR;
          end else begin
            instr_d[27:24] = iByte[3:0];
            state_d        = S_BYTE1;
          end
        end else begin
          state_d = S_BYTE0;
        end
      end
      S_BYTE1: begin
        if (accept_s) begin
          instr_d[23:16] = iByte;
          state_d        = S_BYTE2;
        end else begin
          state_d = S_BYTE1;
        end
      end
      S_BYTE2: begin
        if (accept_s) begin
          instr_d[15:8] = iByte;
          state_d       = S_BYTE3;
        end else begin
          state_d = S_BYTE2;
        end
      end
      S_BYTE3: begin
        if (accept_s) begin
          instr_d[7:0] = iByte;
          state_d      = S_WRITE;
        end else begin
          state_d = S_BYTE3;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 16'd1;
        // count_q is at least 1 here, so the subtraction cannot underflow
        if (addr_q == (count_q - 16'd1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BYTE0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; status outputs are decoded from the next state so they are registered.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      count_q      <= 16'h0000;
      addr_q       <= 16'h0000;
      instr_q      <= 28'h0000000;
      oByteReady   <= 1'b0;
      oWriteEnable <= 1'b0;
      oDone        <= 1'b0;
      oError       <= 1'b0;
      oCpuReset    <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      oByteReady   <= ready_in(state_d);
      oWriteEnable <= (state_d == S_WRITE);
      oDone        <= (state_d == S_DONE);
      oError       <= (state_d == S_ERROR);
      oCpuReset    <= (state_d != S_DONE);
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops and
// compares address, instruction and strobe cycle for every write strobe.
module tb_instruction_loader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iStart;
  logic [7:0]  iByte;
  logic        iByteValid;
  logic        oByteReady;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [27:0] oInstruction;
  logic        oCpuReset;
  logic        oDone;
  logic        oError;

  typedef struct {
    logic [15:0] addr;
    logic [27:0] instr;
    int          cyc;
  } wr_t;

  wr_t sb_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  cyc    = 0;

  instruction_loader #(.MAX_WORDS(256)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStart       (iStart),
    .iByte        (iByte),
    .iByteValid   (iByteValid),
    .oByteReady   (oByteReady),
    .oWriteEnable (oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oInstruction (oInstruction),
    .oCpuReset    (oCpuReset),
    .oDone        (oDone),
    .oError       (oError)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge Clock) begin
    if (oWriteEnable === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {4'h0, oInstruction}, 32'h0);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", {16'h0, oWriteAddress}, {16'h0, e.addr});
        check("wr_instr", {4'h0, oInstruction}, {4'h0, e.instr});
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    bit   ok;
    if (gap > 0) begin
      iByteValid = 1'b0;
      repeat (gap) @(posedge Clock);
      #1;
    end
    iByte      = b;
    iByteValid = 1'b1;
    ok         = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge Clock);
      rdy = oByteReady;
      @(posedge Clock);
      if (rdy) ok = 1'b1;
    end
    #1;
    if (!ok) check("byte_accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic send_word(input logic [15:0] addr, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int gap);
    wr_t e;
    send_byte(b0, gap);
    send_byte(b1, gap);
    send_byte(b2, gap);
    send_byte(b3, gap);
    e.addr  = addr;
    e.instr = {b0[3:0], b1, b2, b3};
    e.cyc   = cyc;
    sb_q.push_back(e);
  endtask

  task automatic drop_valid();
    iByteValid = 1'b0;
  endtask

  task automatic start();
    iStart = 1'b1;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check_end(input string name, input logic done, input logic err, input logic cpurst);
    check({name, "_done"}, {31'h0, oDone}, {31'h0, done});
    check({name, "_error"}, {31'h0, oError}, {31'h0, err});
    check({name, "_cpureset"}, {31'h0, oCpuReset}, {31'h0, cpurst});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    Reset      = 1'b0;
    iStart     = 1'b0;
    iByte      = 8'h00;
    iByteValid = 1'b0;
    settle(3);
    check("rst_we", {31'h0, oWriteEnable}, 32'h0);
    check("rst_ready", {31'h0, oByteReady}, 32'h0);
    check("rst_addr", {16'h0, oWriteAddress}, 32'h0);
    check("rst_instr", {4'h0, oInstruction}, 32'h0);
    check_end("rst", 1'b0, 1'b0, 1'b1);
    Reset = 1'b1;
    settle(2);

    // Two-word program, valid held high
    start();
    check("start_ready", {31'h0, oByteReady}, 32'h1);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(16'd0, 8'h01, 8'h05, 8'h00, 8'h07, 0);
    send_word(16'd1, 8'h05, 8'h00, 8'h02, 8'h00, 0);
    drop_valid();
    settle(3);
    check_end("basic", 1'b1, 1'b0, 1'b0);

    // Same program with 3-cycle stalls between bytes, started from DONE
    start();
    check("reload_cpureset", {31'h0, oCpuReset}, 32'h1);
    send_byte(8'h00, 3); send_byte(8'h02, 3);
    send_word(16'd0, 8'h01, 8'h05, 8'h00, 8'h07, 3);
    send_word(16'd1, 8'h05, 8'h00, 8'h02, 8'h00, 3);
    drop_valid();
    settle(5);
    check_end("stall", 1'b1, 1'b0, 1'b0);

    // Empty program
    start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    drop_valid();
    settle(3);
    check_end("empty", 1'b1, 1'b0, 1'b0);
    check("empty_addr", {16'h0, oWriteAddress}, 32'h0);

    // Count 257 exceeds MAX_WORDS
    start();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    drop_valid();
    settle(3);
    check_end("toolong", 1'b0, 1'b1, 1'b1);
    start();
    check("err_restart_ready", {31'h0, oByteReady}, 32'h1);
    check("err_restart_error", {31'h0, oError}, 32'h0);

    // Exactly MAX_WORDS words is accepted; addresses run 0..255
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      v = i[7:0];
      send_word(16'(i), {4'h0, v[3:0]}, v, ~v, v + 8'd1, 0);
    end
    drop_valid();
    settle(3);
    check_end("full", 1'b1, 1'b0, 1'b1 ^ 1'b1);

    // Reserved nibble set in byte0 of word 1
    start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(16'd0, 8'h01, 8'h02, 8'h03, 8'h04, 0);
    send_byte(8'h15, 0);
    drop_valid();
    settle(3);
    check_end("badbyte0", 1'b0, 1'b1, 1'b1);
    check("badbyte0_ready", {31'h0, oByteReady}, 32'h0);

    // Reset mid-word, then reload from address 0
    start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_word(16'd0, 8'h01, 8'h05, 8'h00, 8'h07, 0);
    send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
    drop_valid();
    Reset = 1'b0;
    settle(1);
    check("midrst_addr", {16'h0, oWriteAddress}, 32'h0);
    check("midrst_instr", {4'h0, oInstruction}, 32'h0);
    check("midrst_ready", {31'h0, oByteReady}, 32'h0);
    check_end("midrst", 1'b0, 1'b0, 1'b1);
    Reset = 1'b1;
    settle(2);
    start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_word(16'd0, 8'h0A, 8'hBC, 8'hDE, 8'hF1, 0);
    drop_valid();
    settle(3);
    check_end("reload", 1'b1, 1'b0, 1'b0);

    check("sb_drained", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256: largest program length accepted, in 28-bit words.
REQ-002 SHALL have port Clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port iStart, input, 1 bit: begins a load when sampled high in IDLE, DONE or ERROR.
REQ-005 SHALL have port iByte, input, 8 bits: program stream byte.
REQ-006 SHALL have port iByteValid, input, 1 bit: iByte is valid this cycle.
REQ-007 SHALL have port oByteReady, output, 1 bit: loader accepts iByte this cycle.
REQ-008 SHALL have port oWriteEnable, output, 1 bit: one-cycle write strobe to the instruction memory.
REQ-009 SHALL have port oWriteAddress, output, 16 bits: instruction memory word address.
REQ-010 SHALL have port oInstruction, output, 28 bits: instruction word to be written.
REQ-011 SHALL have port oCpuReset, output, 1 bit: high holds the MiniAlu core in reset.
REQ-012 SHALL have port oDone, output, 1 bit: high while in DONE.
REQ-013 SHALL have port oError, output, 1 bit: high while in ERROR.

Function
REQ-014 SHALL treat a byte as accepted only in a cycle where iByteValid and oByteReady are both high; no other byte SHALL change state.
REQ-015 SHALL use the stream format: 2-byte word count N (big-endian), then N words of 4 bytes each (big-endian); byte 0 bits [7:4] are reserved and SHALL be zero.
REQ-016 SHALL implement states IDLE, CNT_HI, CNT_LO, BYTE0, BYTE1, BYTE2, BYTE3, WRITE, DONE, ERROR.
REQ-017 SHALL drive oByteReady high in CNT_HI, CNT_LO and BYTE0-BYTE3, and low in all other states.
REQ-018 SHALL move from IDLE, DONE or ERROR to CNT_HI when iStart is high, and SHALL load the word address counter with 0.
REQ-019 SHALL ignore iStart in every other state.
REQ-020 SHALL move CNT_HI to CNT_LO on acceptance and CNT_LO to BYTE0 on acceptance; if N equals 0, CNT_LO SHALL go to DONE instead.
REQ-021 SHALL go from CNT_LO to ERROR when N is greater than MAX_WORDS.
REQ-022 SHALL go from BYTE0 to ERROR on acceptance of a byte with nonzero bits [7:4]; otherwise bits [3:0] SHALL fill instruction [27:24] and the state SHALL advance to BYTE1.
REQ-023 SHALL have BYTE1, BYTE2 and BYTE3 fill instruction [23:16], [15:8] and [7:0] respectively, each advancing on acceptance.
REQ-024 SHALL have BYTE3 advance to WRITE on acceptance.
REQ-025 SHALL assert oWriteEnable for exactly the one cycle spent in WRITE, which is the cycle after the 4th byte is accepted.
REQ-026 SHALL hold oInstruction and oWriteAddress stable during that WRITE cycle.
REQ-027 SHALL make WRITE increment the address counter on exit.
REQ-028 SHALL make WRITE go to DONE if the written word was word N-1, and to BYTE0 otherwise.
REQ-029 SHALL keep oWriteEnable low in every state other than WRITE.
REQ-030 SHALL drive oCpuReset low only in DONE and high in all other states, including ERROR and during a reload.
REQ-031 SHALL use 16-bit address arithmetic with no wrap: the bound N <= MAX_WORDS guarantees oWriteAddress <= MAX_WORDS-1.
REQ-032 SHALL not time out on an iByteValid stall; the loader SHALL wait in its current state indefinitely.

Reset
REQ-033 SHALL, when Reset is low at a rising edge, enter IDLE regardless of the current state, including mid-word and in WRITE.
REQ-034 SHALL, in reset, set oWriteEnable=0, oByteReady=0, oWriteAddress=0, oInstruction=0, oDone=0, oError=0 and oCpuReset=1.
REQ-035 SHALL not produce a write strobe in the cycle in which reset is applied.
REQ-036 SHALL discard any partially assembled word on reset.

Verification
REQ-037 SHALL pass this scenario: iStart, then bytes 00 02 | 01 05 00 07 | 05 00 02 00 with iByteValid held high -> writes 0x1050007 at address 0 and 0x5000200 at address 1, each strobe one cycle after the 4th byte; then oDone=1 and oCpuReset=0.
REQ-038 SHALL pass this scenario: same stream with iByteValid low for 3 cycles between every byte -> identical writes and final state, with no extra strobes.
REQ-039 SHALL pass this scenario: count 00 00 -> DONE directly, zero writes.
REQ-040 SHALL pass this scenario: count 01 01 with MAX_WORDS=256 -> ERROR, oError=1, oCpuReset=1, zero writes; a following iStart returns the loader to CNT_HI.
REQ-041 SHALL pass this scenario: word byte0 = 0x15 -> ERROR, and no write for that word.
REQ-042 SHALL pass this scenario: Reset low after BYTE2 of word 1 -> IDLE, oWriteAddress=0, no strobe; a reload from iStart then writes again starting at address 0.
